// File: rtl/neptuno_joy_pkg.sv
// Shared definitions for the neptUNO DB9 joystick scanner: FSM states,
// chain width, raw sample order and output bit layout.
package neptuno_joy_pkg;

  typedef enum logic [2:0] {
    ST_GAP,
    ST_SEL_SETUP,
    ST_LOAD,
    ST_SHIFT_H,
    ST_SHIFT_L,
    ST_DONE
  } state_t;

  localparam int unsigned JOY_BITS    = 16;
  localparam int unsigned PLAYER_BITS = 8;

  // Output word layout (active high)
  localparam int unsigned JOY_RIGHT = 0;
  localparam int unsigned JOY_LEFT  = 1;
  localparam int unsigned JOY_DOWN  = 2;
  localparam int unsigned JOY_UP    = 3;
  localparam int unsigned JOY_B     = 4;
  localparam int unsigned JOY_C     = 5;
  localparam int unsigned JOY_A     = 6;
  localparam int unsigned JOY_START = 7;

  // Raw sample order within one player's byte of the chain
  localparam int unsigned RAW_UP    = 0;
  localparam int unsigned RAW_DOWN  = 1;
  localparam int unsigned RAW_LEFT  = 2;
  localparam int unsigned RAW_RIGHT = 3;
  localparam int unsigned RAW_B     = 4;
  localparam int unsigned RAW_C     = 5;
  localparam int unsigned RAW_A     = 4;
  localparam int unsigned RAW_START = 5;

  // hi: raw positions 0..5 of the SEL=1 phase; ab: {start, A} from the SEL=0 phase
  function automatic logic [7:0] map_player(input logic [5:0] hi, input logic [1:0] ab);
    logic [7:0] m;
    m            = '0;
    m[JOY_RIGHT] = hi[RAW_RIGHT];
    m[JOY_LEFT]  = hi[RAW_LEFT];
    m[JOY_DOWN]  = hi[RAW_DOWN];
    m[JOY_UP]    = hi[RAW_UP];
    m[JOY_B]     = hi[RAW_B];
    m[JOY_C]     = hi[RAW_C];
    m[JOY_A]     = ab[0];
    m[JOY_START] = ab[1];
    return m;
  endfunction

endpackage

// File: rtl/joy_tick_gen.sv
// Prescaler for the joystick scanner: one-cycle tick every CLK_DIV clocks.
module joy_tick_gen #(
  parameter int unsigned CLK_DIV = 25
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CW = $clog2(CLK_DIV);

  logic [CW-1:0] count;

  assign tick = (count == CW'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst)       count <= '0;
    else if (tick) count <= '0;
    else           count <= count + CW'(1);
  end

endmodule

// File: rtl/neptuno_joy_reader.sv
// DB9 joystick scanner driving the neptUNO 74HC165 chain.
// Define JOY_MEGADRIVE_EN for the two-phase scan that adds A and start.
module neptuno_joy_reader
  import neptuno_joy_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 25,
  parameter int unsigned SCAN_GAP = 64
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic       JOY_DATA,
  output logic       JOY_CLK,
  output logic       JOY_LOAD,
  output logic       JOY_SEL,
  output logic [7:0] joy1,
  output logic [7:0] joy2,
  output logic       joy_valid
);

  localparam int unsigned GAP_W = (SCAN_GAP > 1) ? $clog2(SCAN_GAP) : 1;
  localparam int unsigned P2    = PLAYER_BITS;

  logic                tick;
  logic [1:0]          data_sync;
  state_t              state;
  logic [GAP_W-1:0]    gap_cnt;
  logic [3:0]          k;
  logic [JOY_BITS-1:0] raw;
  logic [JOY_BITS-1:0] hold_hi;
  logic                spare_unused;

  joy_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk (CLOCK_50),
    .rst (RESET),
    .tick(tick)
  );

  always_ff @(posedge CLOCK_50) begin
    if (RESET) data_sync <= '1;
    else       data_sync <= {data_sync[0], JOY_DATA};
  end

`ifdef JOY_MEGADRIVE_EN
  logic                phase;
  logic [JOY_BITS-1:0] hold_lo;
  assign spare_unused = ^{hold_hi[7:6], hold_hi[15:14],
                          hold_lo[3:0], hold_lo[7:6], hold_lo[11:8], hold_lo[15:14]};
`else
  assign JOY_SEL      = 1'b1;
  assign spare_unused = ^{hold_hi[7:6], hold_hi[15:14]};
`endif

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state     <= ST_GAP;
      gap_cnt   <= '0;
      k         <= '0;
      raw       <= '0;
      hold_hi   <= '0;
      JOY_CLK   <= 1'b0;
      JOY_LOAD  <= 1'b1;
      joy1      <= '0;
      joy2      <= '0;
      joy_valid <= 1'b0;
`ifdef JOY_MEGADRIVE_EN
      phase     <= 1'b0;
      hold_lo   <= '0;
      JOY_SEL   <= 1'b1;
`endif
    end else begin
      joy_valid <= 1'b0;
      if (tick) begin
        unique case (state)
          ST_GAP: begin
            if (gap_cnt == GAP_W'(SCAN_GAP - 1)) begin
              gap_cnt <= '0;
              state   <= ST_SEL_SETUP;
`ifdef JOY_MEGADRIVE_EN
              phase   <= 1'b0;
`endif
            end else begin
              gap_cnt <= gap_cnt + GAP_W'(1);
            end
          end
          ST_SEL_SETUP: begin
            JOY_LOAD <= 1'b0;
            state    <= ST_LOAD;
          end
          ST_LOAD: begin
            JOY_LOAD <= 1'b1;
            k        <= '0;
            state    <= ST_SHIFT_H;
          end
          // Sample before raising JOY_CLK: the chain moves to the next bit on this edge
          ST_SHIFT_H: begin
            raw[k]  <= ~data_sync[1];
            JOY_CLK <= 1'b1;
            state   <= ST_SHIFT_L;
          end
          ST_SHIFT_L: begin
            JOY_CLK <= 1'b0;
            if (k == 4'(JOY_BITS - 1)) begin
`ifdef JOY_MEGADRIVE_EN
              if (!phase) begin
                hold_hi <= raw;
                phase   <= 1'b1;
                JOY_SEL <= 1'b0;
                state   <= ST_SEL_SETUP;
              end else begin
                hold_lo <= raw;
                JOY_SEL <= 1'b1;
                state   <= ST_DONE;
              end
`else
              hold_hi <= raw;
              state   <= ST_DONE;
`endif
            end else begin
              k     <= k + 4'd1;
              state <= ST_SHIFT_H;
            end
          end
          ST_DONE: begin
`ifdef JOY_MEGADRIVE_EN
            joy1 <= map_player(hold_hi[RAW_C:RAW_UP], hold_lo[RAW_START:RAW_A]);
            joy2 <= map_player(hold_hi[P2+RAW_C:P2+RAW_UP], hold_lo[P2+RAW_START:P2+RAW_A]);
`else
            joy1 <= map_player(hold_hi[RAW_C:RAW_UP], 2'b00);
            joy2 <= map_player(hold_hi[P2+RAW_C:P2+RAW_UP], 2'b00);
`endif
            joy_valid <= 1'b1;
            state     <= ST_GAP;
          end
          default: state <= ST_GAP;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_neptuno_joy_reader.sv
// Scoreboard bench for neptuno_joy_reader with a behavioural 74HC165 chain.
module tb_neptuno_joy_reader;

  localparam int unsigned CD = 5;
  localparam int unsigned SG = 8;
`ifdef JOY_MEGADRIVE_EN
  localparam bit          MD  = 1'b1;
  localparam int unsigned NPH = 2;
`else
  localparam bit          MD  = 1'b0;
  localparam int unsigned NPH = 1;
`endif
  localparam int unsigned FRAME_CYC = (SG + 34 * NPH + 1) * CD;
  localparam int unsigned SEL_LOW   = MD ? 34 * CD : 0;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       jdata;
  logic       jclk, jload, jsel, valid;
  logic [7:0] joy1, joy2;

  always #5 clk = ~clk;

  neptuno_joy_reader #(.CLK_DIV(CD), .SCAN_GAP(SG)) dut (
    .CLOCK_50 (clk),
    .RESET    (rst),
    .JOY_DATA (jdata),
    .JOY_CLK  (jclk),
    .JOY_LOAD (jload),
    .JOY_SEL  (jsel),
    .joy1     (joy1),
    .joy2     (joy2),
    .joy_valid(valid)
  );

  // Chain model: pressed bits are active low, raw[0] is shifted out first
  logic [15:0] press_hi = '0;
  logic [15:0] press_lo = '0;
  logic [15:0] sr;
  logic        pclk_m;

  always @(posedge clk) begin
    if (rst)               sr <= '1;
    else if (!jload)       sr <= ~(jsel ? press_hi : press_lo);
    else if (jclk && !pclk_m) sr <= {1'b1, sr[15:1]};
    pclk_m <= jclk;
  end
  assign jdata = sr[0];

  typedef struct packed { logic [7:0] j1; logic [7:0] j2; } exp_t;
  typedef struct { logic [15:0] hi; logic [15:0] lo; logic [7:0] e1; logic [7:0] e2; } vec_t;

  exp_t q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  logic       rst_q;
  logic [7:0] prev1, prev2;
  logic       prev_valid;
  bit         hold_bad = 0;

  always @(posedge clk) rst_q <= rst;

  always @(negedge clk) begin
    if (valid) begin
      checks++;
      if (prev_valid === 1'b1) begin
        errors++;
        $display("FAIL valid_width actual=2+ cycles required=1 cycle");
      end
      checks++;
      if (hold_bad) begin
        errors++;
        $display("FAIL output_hold actual=changed required=stable between pulses");
      end
      hold_bad = 0;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid actual=pulse required=none joy1=%h joy2=%h", joy1, joy2);
      end else begin
        e = q.pop_front();
        checks++;
        if (joy1 !== e.j1) begin
          errors++;
          $display("FAIL joy1 actual=%h required=%h", joy1, e.j1);
        end
        checks++;
        if (joy2 !== e.j2) begin
          errors++;
          $display("FAIL joy2 actual=%h required=%h", joy2, e.j2);
        end
      end
    end else if (!rst_q && (joy1 !== prev1 || joy2 !== prev2)) begin
      hold_bad = 1;
    end
    prev1      = joy1;
    prev2      = joy2;
    prev_valid = valid;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push_exp(input vec_t v);
    exp_t t;
    t.j1 = v.e1;
    t.j2 = v.e2;
    q.push_back(t);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (n < int'(FRAME_CYC) + 100) begin
      @(negedge clk);
      n++;
      if (valid) break;
    end
  endtask

  // Entered on the negedge where joy_valid was seen; runs one frame and checks pin timing
  task automatic run_frame(input vec_t v);
    int n, loads, low, sel_low;
    int rises[4];
    logic pc, pl;
    press_hi = v.hi;
    press_lo = v.lo;
    push_exp(v);
    n = 0; loads = 0; low = 0; sel_low = 0;
    for (int i = 0; i < 4; i++) rises[i] = 0;
    pc = jclk;
    pl = jload;
    while (n < int'(FRAME_CYC) + 100) begin
      @(negedge clk);
      n++;
      if (!jload) begin
        low++;
        if (pl) loads++;
      end
      if (jclk && !pc && loads < 4) rises[loads]++;
      if (!jsel) sel_low++;
      pc = jclk;
      pl = jload;
      if (valid) break;
    end
    chk("frame_period", n, FRAME_CYC);
    chk("load_pulses", loads, NPH);
    chk("load_low_cycles", low, NPH * CD);
    chk("clk_rises_phase0", rises[1], 16);
`ifdef JOY_MEGADRIVE_EN
    chk("clk_rises_phase1", rises[2], 16);
`endif
    chk("sel_low_cycles", sel_low, SEL_LOW);
  endtask

  vec_t vecs[7];

  initial begin
    int n, cnt;
    logic pc;
    bit idle_bad;

    vecs[0] = '{hi: 16'h0000, lo: 16'h0000, e1: 8'h00, e2: 8'h00};
    vecs[1] = '{hi: 16'h0001, lo: 16'h0000, e1: 8'h08, e2: 8'h00};
    vecs[2] = '{hi: 16'h3800, lo: 16'h0000, e1: 8'h00, e2: 8'h31};
    vecs[3] = '{hi: 16'h0000, lo: 16'h0030, e1: MD ? 8'hC0 : 8'h00, e2: 8'h00};
    vecs[4] = '{hi: 16'hC1C6, lo: 16'h20C1, e1: 8'h06, e2: MD ? 8'h88 : 8'h08};
    vecs[5] = '{hi: 16'hFFFF, lo: 16'hFFFF, e1: MD ? 8'hFF : 8'h3F, e2: MD ? 8'hFF : 8'h3F};
    vecs[6] = '{hi: 16'h0010, lo: 16'h1010, e1: MD ? 8'h50 : 8'h10, e2: MD ? 8'h40 : 8'h00};

    rst = 1'b1;
    repeat (10) @(negedge clk);
    chk("rst_joy1", joy1, 8'h00);
    chk("rst_joy2", joy2, 8'h00);
    chk("rst_valid", valid, 1'b0);
    chk("rst_clk", jclk, 1'b0);
    chk("rst_load", jload, 1'b1);
    chk("rst_sel", jsel, 1'b1);
    rst = 1'b0;
    push_exp(vecs[0]);

    idle_bad = 0;
    repeat (SG * CD) begin
      @(negedge clk);
      if (jclk !== 1'b0 || jload !== 1'b1 || jsel !== 1'b1 || valid !== 1'b0) idle_bad = 1;
    end
    chk("idle_pins", idle_bad, 0);
    wait_valid(n);
    chk("first_frame_latency", n + SG * CD, FRAME_CYC);

    for (int i = 1; i < 7; i++) run_frame(vecs[i]);

    // Reset while phase 0 bit 7 is being shifted, with buttons pressed
    press_hi = vecs[4].hi;
    press_lo = vecs[4].lo;
    cnt = 0;
    n   = 0;
    pc  = jclk;
    while (cnt < 8 && n < int'(FRAME_CYC)) begin
      @(negedge clk);
      n++;
      if (jclk && !pc) cnt++;
      pc = jclk;
    end
    chk("bit7_reached", cnt, 8);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_joy1", joy1, 8'h00);
    chk("midrst_joy2", joy2, 8'h00);
    chk("midrst_valid", valid, 1'b0);
    chk("midrst_clk", jclk, 1'b0);
    chk("midrst_load", jload, 1'b1);
    chk("midrst_sel", jsel, 1'b1);
    push_exp(vecs[4]);
    wait_valid(n);
    chk("restart_latency", n, FRAME_CYC);

    run_frame(vecs[2]);
    repeat (5) @(negedge clk);
    chk("queue_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
